// File: rtl/alu_seq_if.sv
// Issue/writeback handshake bundle for alu_seq_core: operands and op in, result and flags out.
// master = issue/writeback side, slave = ALU side.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         op;
  logic               mode_signed;
  logic [WIDTH-1:0]   value1;
  logic [WIDTH-1:0]   value2;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               c_out;
  logic               overflow;
  logic               zero;
  logic               div_by_zero;

  modport master (
    output in_valid, op, mode_signed, value1, value2, out_ready,
    input  in_ready, out_valid, result, c_out, overflow, zero, div_by_zero
  );

  modport slave (
    input  in_valid, op, mode_signed, value1, value2, out_ready,
    output in_ready, out_valid, result, c_out, overflow, zero, div_by_zero
  );
endinterface

// File: rtl/alu_seq_core.sv
// Handshaked sequential ALU: add/sub/shift in one cycle, iterative shift-add MUL and restoring DIV.
// Define ALU_FAST_MUL_EN to make MUL combinational and complete in one cycle.
module alu_seq_core #(
  parameter int unsigned WIDTH = 8
) (
  input logic      clock,
  input logic      reset_n,
  alu_seq_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH + 1);
  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpMul = 3'd2;
  localparam logic [2:0] OpDiv = 3'd3;
  localparam logic [2:0] OpShl = 3'd4;
  localparam logic [2:0] OpShr = 3'd5;
`ifdef ALU_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StExec, StMulIt, StDivIt, StDone} state_e;

  state_e             r_state;
  logic               r_in_ready, r_out_valid;
  logic [2*WIDTH-1:0] r_result;
  logic               r_c_out, r_overflow, r_zero, r_dbz;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [2:0]         r_op;
  logic               r_sgn, r_qneg, r_rneg;
  logic [CW-1:0]      r_cnt;
  // r_x: magnitude of B (multiplicand / divisor); r_y: magnitude of A (multiplier / quotient)
  logic [2*WIDTH-1:0] r_acc, r_x;
  logic [WIDTH-1:0]   r_y;

  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  assign w_a_neg = bus.mode_signed & bus.value1[WIDTH-1];
  assign w_b_neg = bus.mode_signed & bus.value2[WIDTH-1];
  assign w_a_mag = w_a_neg ? -bus.value1 : bus.value1;
  assign w_b_mag = w_b_neg ? -bus.value2 : bus.value2;

  logic [2*WIDTH-1:0] w_mul_mag, w_prod;
  logic               w_mul_ov;
`ifdef ALU_FAST_MUL_EN
  assign w_mul_mag = r_x * {{WIDTH{1'b0}}, r_y};
`else
  assign w_mul_mag = r_acc;
`endif
  assign w_prod   = r_qneg ? -w_mul_mag : w_mul_mag;
  assign w_mul_ov = r_sgn ? (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}})
                          : (w_prod[2*WIDTH-1:WIDTH] != '0);

  logic [WIDTH:0]   w_rem_sh, w_rem_try;
  logic             w_q_bit, w_div_ov;
  logic [WIDTH-1:0] w_quo, w_rem;
  assign w_rem_sh  = {r_acc[WIDTH-1:0], r_y[WIDTH-1]};
  assign w_rem_try = w_rem_sh - {1'b0, r_x[WIDTH-1:0]};
  assign w_q_bit   = (w_rem_sh >= {1'b0, r_x[WIDTH-1:0]});
  assign w_quo     = r_qneg ? -r_y : r_y;
  assign w_rem     = r_rneg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_div_ov  = r_sgn & (r_a == {1'b1, {(WIDTH-1){1'b0}}}) & (&r_b);

  logic [WIDTH:0]        w_sum, w_diff, w_shl, w_shr_l;
  logic signed [WIDTH:0] w_shr_a;
  logic [SHW-1:0]        w_amt;
  logic [2*WIDTH-1:0]    w_ex_res;
  logic                  w_ex_c, w_ex_ov, w_ex_z, w_ex_dbz;

  // Shifts carry one guard bit so the last bit shifted out lands in it.
  assign w_amt   = r_b[SHW-1:0];
  assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
  assign w_shl   = {1'b0, r_a} << w_amt;
  assign w_shr_l = {r_a, 1'b0} >> w_amt;
  assign w_shr_a = $signed({r_a, 1'b0}) >>> w_amt;

  always_comb begin
    w_ex_res = '0;
    w_ex_c   = 1'b0;
    w_ex_ov  = 1'b0;
    w_ex_dbz = 1'b0;
    case (r_op)
      OpAdd: begin
        w_ex_res[WIDTH-1:0] = w_sum[WIDTH-1:0];
        w_ex_c  = w_sum[WIDTH];
        w_ex_ov = r_sgn ? ((r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]))
                        : w_sum[WIDTH];
      end
      OpSub: begin
        w_ex_res[WIDTH-1:0] = w_diff[WIDTH-1:0];
        w_ex_c  = w_diff[WIDTH];
        w_ex_ov = r_sgn ? ((r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]))
                        : w_diff[WIDTH];
      end
      OpMul: begin
        w_ex_res = w_prod;
        w_ex_ov  = w_mul_ov;
      end
      OpDiv: begin
        w_ex_res = {r_a, {WIDTH{1'b1}}};
        w_ex_dbz = 1'b1;
      end
      OpShl: begin
        w_ex_res[WIDTH-1:0] = w_shl[WIDTH-1:0];
        w_ex_c = w_shl[WIDTH];
      end
      OpShr: begin
        w_ex_res[WIDTH-1:0] = r_sgn ? w_shr_a[WIDTH:1] : w_shr_l[WIDTH:1];
        w_ex_c = r_sgn ? w_shr_a[0] : w_shr_l[0];
      end
      default: ;
    endcase
    w_ex_z = (r_op == OpMul) ? (w_prod == '0) : (w_ex_res[WIDTH-1:0] == '0);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_c_out     <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_dbz       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_sgn       <= 1'b0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_x         <= '0;
      r_y         <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_a        <= bus.value1;
            r_b        <= bus.value2;
            r_op       <= bus.op;
            r_sgn      <= bus.mode_signed;
            r_qneg     <= w_a_neg ^ w_b_neg;
            r_rneg     <= w_a_neg;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_x        <= {{WIDTH{1'b0}}, w_b_mag};
            r_y        <= w_a_mag;
            r_in_ready <= 1'b0;
            if (bus.op == OpDiv && bus.value2 != '0) r_state <= StDivIt;
            else if (bus.op == OpMul && !FastMul)    r_state <= StMulIt;
            else                                     r_state <= StExec;
          end
        end
        StExec: begin
          r_result    <= w_ex_res;
          r_c_out     <= w_ex_c;
          r_overflow  <= w_ex_ov;
          r_zero      <= w_ex_z;
          r_dbz       <= w_ex_dbz;
          r_out_valid <= 1'b1;
          r_state     <= StDone;
        end
        StMulIt: begin
          if (r_cnt == CW'(WIDTH)) begin
            r_result    <= w_prod;
            r_c_out     <= 1'b0;
            r_overflow  <= w_mul_ov;
            r_zero      <= (w_prod == '0);
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            if (r_y[0]) r_acc <= r_acc + r_x;
            r_x   <= r_x << 1;
            r_y   <= r_y >> 1;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StDivIt: begin
          if (r_cnt == CW'(WIDTH)) begin
            r_result    <= {w_rem, w_quo};
            r_c_out     <= 1'b0;
            r_overflow  <= w_div_ov;
            r_zero      <= (w_quo == '0);
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_acc <= {{(WIDTH-1){1'b0}}, (w_q_bit ? w_rem_try : w_rem_sh)};
            r_y   <= {r_y[WIDTH-2:0], w_q_bit};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.result      = r_result;
  assign bus.c_out       = r_c_out;
  assign bus.overflow    = r_overflow;
  assign bus.zero        = r_zero;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core (WIDTH=8): directed vector table, random ops against an integer model,
// backpressure hold and mid-MUL reset sequences.
module tb_alu_seq_core;
  localparam int unsigned W = 8;
`ifdef ALU_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = W + 1;
`endif
  localparam int DivLat = W + 1;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        ov;
    logic        z;
    logic        dbz;
  } res_t;

  typedef struct {
    logic [2:0] op;
    logic       sgn;
    logic [7:0] a;
    logic [7:0] b;
    res_t       exp;
    int         lat;
    int         hold;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq_core #(.WIDTH(W)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference computed from the arithmetic definitions using plain integers.
  function automatic res_t model(input logic [2:0] op, input logic sgn,
                                 input logic [7:0] a, input logic [7:0] b);
    res_t r;
    int ua, ub, sa, sb, x, q, m, amt;
    r   = '0;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    amt = ub % 8;
    case (op)
      3'd0: begin
        r.res = 16'((ua + ub) & 255);
        r.c   = (ua + ub) > 255;
        r.ov  = sgn ? ((sa + sb) > 127 || (sa + sb) < -128) : r.c;
      end
      3'd1: begin
        r.res = 16'((ua - ub) & 255);
        r.c   = ua < ub;
        r.ov  = sgn ? ((sa - sb) > 127 || (sa - sb) < -128) : r.c;
      end
      3'd2: begin
        x     = sgn ? sa * sb : ua * ub;
        r.res = 16'(x);
        r.ov  = sgn ? (x > 127 || x < -128) : (x > 255);
      end
      3'd3: begin
        if (ub == 0) begin
          r.res = {a, 8'hFF};
          r.dbz = 1'b1;
        end else if (sgn && sa == -128 && sb == -1) begin
          r.res = 16'h0080;
          r.ov  = 1'b1;
        end else begin
          q     = sgn ? sa / sb : ua / ub;
          m     = sgn ? sa % sb : ua % ub;
          r.res = {8'(m), 8'(q)};
        end
      end
      3'd4: begin
        r.res = 16'((ua << amt) & 255);
        r.c   = (amt != 0) && (((ua >> (8 - amt)) & 1) == 1);
      end
      3'd5: begin
        x     = sgn ? (sa >>> amt) : (ua >> amt);
        r.res = 16'(x & 255);
        r.c   = (amt != 0) && (((ua >> (amt - 1)) & 1) == 1);
      end
      default: r.res = 16'h0000;
    endcase
    if (op == 3'd2)      r.z = (r.res == 16'h0000);
    else                 r.z = (r.res[7:0] == 8'h00);
    if (op == 3'd3 && ub == 0) r.z = 1'b0;
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [7:0] b);
    if (op == 3'd2) return MulLat;
    if (op == 3'd3 && b != 8'h00) return DivLat;
    return 1;
  endfunction

  task automatic do_op(input string name, input logic [2:0] op, input logic sgn,
                       input logic [7:0] a, input logic [7:0] b, input res_t exp,
                       input int elat, input int hold);
    int n;
    int lat;
    @(negedge clock);
    bus.in_valid    = 1'b1;
    bus.op          = op;
    bus.mode_signed = sgn;
    bus.value1      = a;
    bus.value2      = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk({name, ".accept"}, 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1;
    // Scramble inputs after accept; the captured operands must be used.
    bus.in_valid    = 1'b0;
    bus.op          = 3'($urandom);
    bus.mode_signed = 1'($urandom);
    bus.value1      = 8'($urandom);
    bus.value2      = 8'($urandom);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk({name, ".latency"}, 32'(lat), 32'(elat));
    chk({name, ".result"}, 32'(bus.result), 32'(exp.res));
    chk({name, ".c_out"}, 32'(bus.c_out), 32'(exp.c));
    chk({name, ".overflow"}, 32'(bus.overflow), 32'(exp.ov));
    chk({name, ".zero"}, 32'(bus.zero), 32'(exp.z));
    chk({name, ".div_by_zero"}, 32'(bus.div_by_zero), 32'(exp.dbz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      chk({name, ".hold"},
          32'({bus.out_valid, bus.in_ready, bus.result, bus.c_out, bus.overflow, bus.zero,
               bus.div_by_zero}),
          32'({2'b10, exp.res, exp.c, exp.ov, exp.z, exp.dbz}));
    end
    @(negedge clock);
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk({name, ".release"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
    bus.out_ready = 1'b0;
  endtask

  vec_t tbl [22];

  initial begin
    tbl[0]  = '{3'd0, 1'b0, 8'h8A, 8'h8A, '{16'h0014, 1'b1, 1'b1, 1'b0, 1'b0}, 1, 0};
    tbl[1]  = '{3'd0, 1'b1, 8'h8A, 8'h8A, '{16'h0014, 1'b1, 1'b1, 1'b0, 1'b0}, 1, 1};
    tbl[2]  = '{3'd1, 1'b1, 8'h8A, 8'h4A, '{16'h0040, 1'b0, 1'b1, 1'b0, 1'b0}, 1, 0};
    tbl[3]  = '{3'd1, 1'b0, 8'h4A, 8'h8A, '{16'h00C0, 1'b1, 1'b1, 1'b0, 1'b0}, 1, 0};
    tbl[4]  = '{3'd2, 1'b1, 8'hAB, 8'h5A, '{16'hE21E, 1'b0, 1'b1, 1'b0, 1'b0}, MulLat, 5};
    tbl[5]  = '{3'd2, 1'b0, 8'hAB, 8'h5A, '{16'h3C1E, 1'b0, 1'b1, 1'b0, 1'b0}, MulLat, 0};
    tbl[6]  = '{3'd3, 1'b0, 8'hBF, 8'h52, '{16'h1B02, 1'b0, 1'b0, 1'b0, 1'b0}, DivLat, 2};
    tbl[7]  = '{3'd3, 1'b0, 8'hBF, 8'h00, '{16'hBFFF, 1'b0, 1'b0, 1'b0, 1'b1}, 1, 0};
    tbl[8]  = '{3'd3, 1'b1, 8'h80, 8'hFF, '{16'h0080, 1'b0, 1'b1, 1'b0, 1'b0}, DivLat, 0};
    tbl[9]  = '{3'd4, 1'b0, 8'hA7, 8'h01, '{16'h004E, 1'b1, 1'b0, 1'b0, 1'b0}, 1, 0};
    tbl[10] = '{3'd5, 1'b1, 8'hA7, 8'h02, '{16'h00E9, 1'b1, 1'b0, 1'b0, 1'b0}, 1, 0};
    tbl[11] = '{3'd5, 1'b0, 8'hA7, 8'h02, '{16'h0029, 1'b1, 1'b0, 1'b0, 1'b0}, 1, 0};
    tbl[12] = '{3'd6, 1'b1, 8'h12, 8'h34, '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}, 1, 0};
    tbl[13] = '{3'd3, 1'b1, 8'hF9, 8'h02, '{16'hFFFD, 1'b0, 1'b0, 1'b0, 1'b0}, DivLat, 0};
    tbl[14] = '{3'd4, 1'b0, 8'hA7, 8'h00, '{16'h00A7, 1'b0, 1'b0, 1'b0, 1'b0}, 1, 0};
    tbl[15] = '{3'd2, 1'b1, 8'h80, 8'h80, '{16'h4000, 1'b0, 1'b1, 1'b0, 1'b0}, MulLat, 0};
    tbl[16] = '{3'd0, 1'b0, 8'h00, 8'h00, '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}, 1, 0};
    tbl[17] = '{3'd2, 1'b0, 8'h00, 8'h37, '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}, MulLat, 0};
    tbl[18] = '{3'd3, 1'b1, 8'h05, 8'hF9, '{16'h0500, 1'b0, 1'b0, 1'b1, 1'b0}, DivLat, 0};
    tbl[19] = '{3'd4, 1'b0, 8'h01, 8'h07, '{16'h0080, 1'b0, 1'b0, 1'b0, 1'b0}, 1, 0};
    tbl[20] = '{3'd5, 1'b1, 8'h80, 8'h07, '{16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0}, 1, 0};
    tbl[21] = '{3'd3, 1'b1, 8'h85, 8'h00, '{16'h85FF, 1'b0, 1'b0, 1'b0, 1'b1}, 1, 0};

    reset_n         = 1'b0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.op          = 3'd0;
    bus.mode_signed = 1'b0;
    bus.value1      = 8'h00;
    bus.value2      = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    chk("reset.handshake", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    chk("reset.outputs",
        32'({bus.result, bus.c_out, bus.overflow, bus.zero, bus.div_by_zero}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].exp,
            tbl[i].lat, tbl[i].hold);
    end

    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      logic       sgn;
      logic [7:0] a, b;
      op  = 3'($urandom_range(0, 7));
      sgn = 1'($urandom);
      a   = 8'($urandom);
      b   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      do_op($sformatf("rand%0d", i), op, sgn, a, b, model(op, sgn, a, b), exp_lat(op, b),
            $urandom_range(0, 2));
    end

    // Leave a nonzero result behind, then reset in the middle of a MUL.
    do_op("pre_reset", 3'd0, 1'b0, 8'h12, 8'h34, model(3'd0, 1'b0, 8'h12, 8'h34), 1, 0);
    @(negedge clock);
    bus.in_valid    = 1'b1;
    bus.op          = 3'd2;
    bus.mode_signed = 1'b1;
    bus.value1      = 8'hAB;
    bus.value2      = 8'h5A;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    chk("midmul_reset.handshake", 32'({bus.out_valid, bus.in_ready}), 32'b01);
    chk("midmul_reset.result", 32'(bus.result), 32'd0);
    chk("midmul_reset.flags",
        32'({bus.c_out, bus.overflow, bus.zero, bus.div_by_zero}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    do_op("post_reset", 3'd2, 1'b0, 8'hAB, 8'h5A, model(3'd2, 1'b0, 8'hAB, 8'h5A), MulLat, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks",
             n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
